i2c_master_seq: RTL and testbench

Clocked, synthesizable successor to the behavioural bench I2C master driver. It replays a programmed sequence of up to MAX_BYTES 9-bit blocks onto an open-drain I2C bus, and lets the bench place a repeated START or STOP after any byte. It adds three things the bench driver lacks: SCL clock-stretch handling with timeout, per-bit SDA readback, and per-byte NACK recording. It sits on the bench side of the i2c_passthru, facing the master port, and can also act as a synthesizable master for FPGA bring-up.

---
 rtl/i2c_master_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_master_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_seq.sv
// Replays up to MAX_BYTES 9-bit blocks onto an open-drain I2C bus, with optional RS/STOP after any byte.
// SDA launches 2 cycles after the i_start edge. A slave may hold SCL low (stretch); the transfer aborts after STRETCH_MAX cycles.
module i2c_master_seq #(
    parameter int MAX_BYTES   = 8,
    parameter int CNT_W       = 16,
    parameter int STRETCH_MAX = 65535
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [CNT_W-1:0]       i_scl_lo_cycles,
    input  logic [CNT_W-1:0]       i_scl_hi_cycles,
    input  logic [3:0]             i_num_bytes,
    input  logic [3:0]             i_rs_after_byte,
    input  logic [3:0]             i_stop_after_byte,
    input  logic [9*MAX_BYTES-1:0] i_bytes,
    input  logic                   i_scl,
    input  logic                   i_sda,
    output logic                   o_scl,
    output logic                   o_sda,
    output logic                   o_idle,
    output logic                   o_done,
    output logic [9*MAX_BYTES-1:0] o_rx_bytes,
    output logic [MAX_BYTES-1:0]   o_nack_mask,
    output logic                   o_timeout
);

    localparam int STR_W = (STRETCH_MAX < 2) ? 1 : $clog2(STRETCH_MAX + 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_MAX - 1);
    localparam int IDX_W = $clog2(9 * MAX_BYTES);
    localparam int BW    = (MAX_BYTES > 2) ? $clog2(MAX_BYTES) : 1;
    localparam logic [3:0] MAXB = 4'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_BIT_LO, S_STRETCH, S_BIT_HI,
        S_RS_LO, S_RS_HI, S_STOP_LO, S_STOP_HI, S_BUS_FREE
    } state_t;

    state_t                 r_state, r_ret;
    logic [CNT_W-1:0]       r_cnt, r_lo_last, r_hi_last;
    logic [STR_W-1:0]       r_str;
    logic [3:0]             r_num, r_rs, r_stop, r_byte, r_bit;
    logic [9*MAX_BYTES-1:0] r_tx;
    logic                   r_start_s1, r_start_s2;
    logic                   r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;

    logic [7:0]       w_lin;
    logic [IDX_W-1:0] w_bit_idx;
    logic [3:0]       w_num_cl;
    logic             w_rise, w_lo_done, w_hi_done, w_last_byte;

    assign w_lin       = 8'(r_byte) * 8'd9 + 8'(r_bit);
    assign w_bit_idx   = IDX_W'(w_lin);
    assign w_num_cl    = (i_num_bytes > MAXB) ? MAXB : i_num_bytes;
    assign w_rise      = r_start_s1 & ~r_start_s2;
    assign w_lo_done   = (r_cnt == r_lo_last);
    assign w_hi_done   = (r_cnt == r_hi_last);
    assign w_last_byte = (r_byte == r_num - 4'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ret       <= S_IDLE;
            r_cnt       <= '0;
            r_lo_last   <= '0;
            r_hi_last   <= '0;
            r_str       <= '0;
            r_num       <= '0;
            r_rs        <= 4'hF;
            r_stop      <= 4'hF;
            r_byte      <= '0;
            r_bit       <= '0;
            r_tx        <= '0;
            r_start_s1  <= 1'b0;
            r_start_s2  <= 1'b0;
            r_scl_s1    <= 1'b1;
            r_scl_s2    <= 1'b1;
            r_sda_s1    <= 1'b1;
            r_sda_s2    <= 1'b1;
            o_scl       <= 1'b1;
            o_sda       <= 1'b1;
            o_idle      <= 1'b1;
            o_done      <= 1'b0;
            o_rx_bytes  <= '0;
            o_nack_mask <= '0;
            o_timeout   <= 1'b0;
        end else begin
            r_start_s1 <= i_start;
            r_start_s2 <= r_start_s1;
            r_scl_s1   <= i_scl;
            r_scl_s2   <= r_scl_s1;
            r_sda_s1   <= i_sda;
            r_sda_s2   <= r_sda_s1;
            o_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        if (w_num_cl == 4'd0) begin
                            o_done <= 1'b1;
                        end else begin
                            r_lo_last   <= (i_scl_lo_cycles == '0) ? '0 : i_scl_lo_cycles - CNT_W'(1);
                            r_hi_last   <= (i_scl_hi_cycles == '0) ? '0 : i_scl_hi_cycles - CNT_W'(1);
                            r_num       <= w_num_cl;
                            r_rs        <= i_rs_after_byte;
                            r_stop      <= i_stop_after_byte;
                            r_tx        <= i_bytes;
                            o_rx_bytes  <= '0;
                            o_nack_mask <= '0;
                            o_timeout   <= 1'b0;
                            r_byte      <= '0;
                            r_bit       <= 4'd8;
                            r_cnt       <= '0;
                            o_sda       <= 1'b0;
                            o_idle      <= 1'b0;
                            r_state     <= S_START;
                        end
                    end
                end
                // Shared by the first START, repeated START and START after BUS_FREE: SDA is already low here.
                S_START: begin
                    if (w_hi_done) begin
                        o_scl   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_BIT_LO;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BIT_LO: begin
                    if (r_cnt == '0) o_sda <= r_tx[w_bit_idx];
                    if (w_lo_done) begin
                        o_scl   <= 1'b1;
                        r_str   <= '0;
                        r_ret   <= S_BIT_HI;
                        r_state <= S_STRETCH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // The synchronizer delay is spent here too, so it counts against the stretch budget.
                S_STRETCH: begin
                    if (r_scl_s2) begin
                        r_cnt   <= '0;
                        r_state <= r_ret;
                    end else if (r_str >= STR_LAST) begin
                        o_scl     <= 1'b1;
                        o_sda     <= 1'b1;
                        o_timeout <= 1'b1;
                        o_done    <= 1'b1;
                        o_idle    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_str <= r_str + STR_W'(1);
                    end
                end
                S_BIT_HI: begin
                    if (w_hi_done) begin
                        o_rx_bytes[w_bit_idx] <= r_sda_s2;
                        if (r_bit == 4'd0) o_nack_mask[BW'(r_byte)] <= r_tx[w_bit_idx] & r_sda_s2;
                        o_scl <= 1'b0;
                        r_cnt <= '0;
                        if (r_bit != 4'd0) begin
                            r_bit   <= r_bit - 4'd1;
                            r_state <= S_BIT_LO;
                        end else begin
                            r_bit  <= 4'd8;
                            r_byte <= r_byte + 4'd1;
                            if (r_byte == r_stop || w_last_byte) r_state <= S_STOP_LO;
                            else if (r_byte == r_rs)             r_state <= S_RS_LO;
                            else                                 r_state <= S_BIT_LO;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RS_LO, S_STOP_LO: begin
                    if (r_cnt == '0) o_sda <= (r_state == S_RS_LO);
                    if (w_lo_done) begin
                        o_scl   <= 1'b1;
                        r_str   <= '0;
                        r_ret   <= (r_state == S_RS_LO) ? S_RS_HI : S_STOP_HI;
                        r_state <= S_STRETCH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RS_HI: begin
                    if (w_hi_done) begin
                        o_sda   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP_HI: begin
                    if (w_hi_done) begin
                        o_sda   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUS_FREE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BUS_FREE: begin
                    if (w_hi_done) begin
                        r_cnt <= '0;
                        if (r_byte < r_num) begin
                            o_sda   <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            o_idle  <= 1'b1;
                            o_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq: two instances (stretch limits 100 and 20) with a small ACK/stretch slave on instance A.
module tb_i2c_master_seq;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_start_a, i_start_b;
    logic [15:0] lo, hi;
    logic [3:0]  num, rs, stp;
    logic [71:0] bytes;

    logic        o_scl_a, o_sda_a, o_idle_a, o_done_a, o_timeout_a;
    logic [71:0] o_rx_a;
    logic [7:0]  o_nack_a;
    logic        o_scl_b, o_sda_b, o_idle_b, o_done_b, o_timeout_b;
    logic [71:0] o_rx_b;
    logic [7:0]  o_nack_b;

    logic slv_scl_a = 1'b1, slv_sda_a = 1'b1, slv_scl_b = 1'b1;
    wire  bus_scl_a = o_scl_a & slv_scl_a;
    wire  bus_sda_a = o_sda_a & slv_sda_a;
    wire  bus_scl_b = o_scl_b & slv_scl_b;
    wire  bus_sda_b = o_sda_b;

    int vectors = 0, miscompares = 0;
    int last_sda_n;
    bit ack_en = 1'b1;
    int str_req = 0;

    always #5 clk = ~clk;

    i2c_master_seq #(.MAX_BYTES(8), .CNT_W(16), .STRETCH_MAX(100)) dut_a (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start_a),
        .i_scl_lo_cycles(lo), .i_scl_hi_cycles(hi), .i_num_bytes(num),
        .i_rs_after_byte(rs), .i_stop_after_byte(stp), .i_bytes(bytes),
        .i_scl(bus_scl_a), .i_sda(bus_sda_a), .o_scl(o_scl_a), .o_sda(o_sda_a),
        .o_idle(o_idle_a), .o_done(o_done_a), .o_rx_bytes(o_rx_a),
        .o_nack_mask(o_nack_a), .o_timeout(o_timeout_a));

    i2c_master_seq #(.MAX_BYTES(8), .CNT_W(16), .STRETCH_MAX(20)) dut_b (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start_b),
        .i_scl_lo_cycles(lo), .i_scl_hi_cycles(hi), .i_num_bytes(num),
        .i_rs_after_byte(rs), .i_stop_after_byte(stp), .i_bytes(bytes),
        .i_scl(bus_scl_b), .i_sda(bus_sda_b), .o_scl(o_scl_b), .o_sda(o_sda_b),
        .o_idle(o_idle_b), .o_done(o_done_b), .o_rx_bytes(o_rx_b),
        .o_nack_mask(o_nack_b), .o_timeout(o_timeout_b));

    // Slave on bus A: counts START/STOP, ACKs each byte when enabled, optionally stretches after the 3rd SCL rise.
    int   n_start = 0, n_stop = 0, bitcnt = 0, str_left = 0;
    bit   str_done = 1'b0;
    logic p_scl = 1'b1, p_sda = 1'b1, cs, cd;
    always @(negedge clk) begin
        cs = bus_scl_a;
        cd = bus_sda_a;
        if (str_left > 0) begin
            str_left--;
            if (str_left == 0) slv_scl_a = 1'b1;
        end
        if (p_scl && cs && p_sda && !cd) begin
            n_start++;
            bitcnt   = 0;
            str_done = 1'b0;
        end
        if (p_scl && cs && !p_sda && cd) n_stop++;
        if (!p_scl && cs) bitcnt++;
        if (p_scl && !cs) begin
            slv_sda_a = !(ack_en && bitcnt == 8);
            if (bitcnt == 9) bitcnt = 0;
            if (bitcnt == 3 && str_req > 0 && !str_done) begin
                slv_scl_a = 1'b0;
                str_left  = str_req;
                str_done  = 1'b1;
            end
        end
        p_scl = cs;
        p_sda = cd;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [8:0] b0, input logic [8:0] b1,
                                       input logic [8:0] b2, input logic [8:0] b3);
        mk = {36'b0, b3, b2, b1, b0};
    endfunction

    task automatic cfg(input logic [3:0] n, input logic [3:0] r, input logic [3:0] s, input logic [71:0] b);
        lo = 16'd4; hi = 16'd3; num = n; rs = r; stp = s; bytes = b;
    endtask

    // Raises start, counts falling clock edges until o_done, then checks latency and the one-cycle pulse.
    task automatic go(input bit sel, input int exp_lat, input string tag);
        int n;
        bit seen;
        n = 0; seen = 1'b0; last_sda_n = 0;
        @(negedge clk);
        if (sel) i_start_b = 1'b1; else i_start_a = 1'b1;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (last_sda_n == 0 && !(sel ? o_sda_b : o_sda_a)) last_sda_n = n;
            seen = sel ? o_done_b : o_done_a;
        end
        chk({tag, " latency"}, 72'(n), 72'(exp_lat));
        chk({tag, " idle at done"}, 72'(sel ? o_idle_b : o_idle_a), 72'd1);
        @(negedge clk);
        chk({tag, " done pulse"}, 72'(sel ? o_done_b : o_done_a), 72'd0);
        i_start_a = 1'b0;
        i_start_b = 1'b0;
    endtask

    initial begin
        int s0, p0, n, falls;
        bit seen;
        logic prev;
        i_rst_n = 1'b0; i_start_a = 1'b0; i_start_b = 1'b0;
        cfg(4'd2, 4'hF, 4'hF, mk(9'h0A1, 9'h0FF, 9'h0, 9'h0));
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("rst scl", 72'(o_scl_a), 72'd1);
        chk("rst sda", 72'(o_sda_a), 72'd1);
        chk("rst idle", 72'(o_idle_a), 72'd1);
        chk("rst done", 72'(o_done_a), 72'd0);
        chk("rst timeout", 72'(o_timeout_a), 72'd0);
        chk("rst rx", o_rx_a, 72'd0);
        chk("rst nack", 72'(o_nack_a), 72'd0);

        s0 = n_start; p0 = n_stop;
        go(1'b0, 198, "t1");
        chk("t1 sda launch", 72'(last_sda_n), 72'd2);
        chk("t1 rx", o_rx_a, mk(9'h0A0, 9'h0FE, 9'h0, 9'h0));
        chk("t1 nack", 72'(o_nack_a), 72'd0);
        chk("t1 starts", 72'(n_start - s0), 72'd1);
        chk("t1 stops", 72'(n_stop - p0), 72'd1);

        cfg(4'd3, 4'd0, 4'hF, mk(9'h0A1, 9'h155, 9'h0FF, 9'h0));
        s0 = n_start; p0 = n_stop;
        go(1'b0, 301, "rs");
        chk("rs rx", o_rx_a, mk(9'h0A0, 9'h154, 9'h0FE, 9'h0));
        chk("rs starts", 72'(n_start - s0), 72'd2);
        chk("rs stops", 72'(n_stop - p0), 72'd1);

        cfg(4'd4, 4'd1, 4'd1, mk(9'h0A1, 9'h0FF, 9'h155, 9'h003));
        s0 = n_start; p0 = n_stop;
        go(1'b0, 394, "stop");
        chk("stop rx", o_rx_a, mk(9'h0A0, 9'h0FE, 9'h154, 9'h002));
        chk("stop starts", 72'(n_start - s0), 72'd2);
        chk("stop stops", 72'(n_stop - p0), 72'd2);

        cfg(4'd2, 4'hF, 4'hF, mk(9'h0A1, 9'h0FF, 9'h0, 9'h0));
        str_req = 50;
        go(1'b0, 244, "stretch");
        str_req = 0;
        chk("stretch rx", o_rx_a, mk(9'h0A0, 9'h0FE, 9'h0, 9'h0));
        chk("stretch timeout", 72'(o_timeout_a), 72'd0);

        @(negedge clk);
        i_start_b = 1'b1;
        falls = 0; prev = 1'b1; n = 0;
        while (falls < 4 && n < 1000) begin
            @(negedge clk);
            n++;
            if (prev && !o_scl_b) falls++;
            prev = o_scl_b;
        end
        slv_scl_b = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            n++;
            seen = o_done_b;
        end
        chk("abort latency", 72'(n), 72'd24);
        chk("abort timeout", 72'(o_timeout_b), 72'd1);
        chk("abort scl", 72'(o_scl_b), 72'd1);
        chk("abort sda", 72'(o_sda_b), 72'd1);
        chk("abort idle", 72'(o_idle_b), 72'd1);
        slv_scl_b = 1'b1;
        i_start_b = 1'b0;
        go(1'b1, 198, "b restart");
        chk("b timeout cleared", 72'(o_timeout_b), 72'd0);
        chk("b nack", 72'(o_nack_b), 72'h03);

        ack_en = 1'b0;
        cfg(4'd3, 4'd7, 4'hF, mk(9'h0A1, 9'h0FF, 9'h155, 9'h0));
        go(1'b0, 288, "nack");
        chk("nack mask", 72'(o_nack_a), 72'h07);
        chk("nack rx", o_rx_a, mk(9'h0A1, 9'h0FF, 9'h155, 9'h0));

        cfg(4'd0, 4'hF, 4'hF, mk(9'h0A1, 9'h0FF, 9'h155, 9'h0));
        s0 = n_start;
        go(1'b0, 2, "noop");
        chk("noop starts", 72'(n_start - s0), 72'd0);

        cfg(4'd3, 4'hF, 4'hF, mk(9'h0A1, 9'h0FF, 9'h155, 9'h0));
        @(negedge clk);
        i_start_a = 1'b1;
        repeat (45) @(negedge clk);
        n = 0;
        while (o_scl_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid scl low", 72'(o_scl_a), 72'd0);
        chk("mid busy", 72'(o_idle_a), 72'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst scl", 72'(o_scl_a), 72'd1);
        chk("arst sda", 72'(o_sda_a), 72'd1);
        chk("arst idle", 72'(o_idle_a), 72'd1);
        i_start_a = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post rst idle", 72'(o_idle_a), 72'd1);
        chk("post rst nack", 72'(o_nack_a), 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
